// File: rtl/mux4to1_pkg.sv
// Shared select encoding for the 4:1 steering mux and its combinational core.
package mux4to1_pkg;

    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_comb_core.sv
// Pure combinational 4:1 select; every select code is decoded, so no latch is inferred.
module mux4_comb_core
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] mux_out
);

    always_comb begin
        mux_out = i0;
        case (sel)
            SEL_I0: mux_out = i0;
            SEL_I1: mux_out = i1;
            SEL_I2: mux_out = i2;
            SEL_I3: mux_out = i3;
        endcase
    end

endmodule

// File: rtl/mux4to1_reg.sv
// 4:1 datapath steering mux with an optional one-cycle output register and valid qualifier.
module mux4to1_reg
    import mux4to1_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit REGISTER_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       sel_q
);

    // Stage p0: select decode
    logic [SEL_W-1:0] sel_p0;
    logic [WIDTH-1:0] mux_p0;

    assign sel_p0 = {s1, s0};

    mux4_comb_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i0     (i0),
        .i1     (i1),
        .i2     (i2),
        .i3     (i3),
        .sel    (sel_p0),
        .mux_out(mux_p0)
    );

    generate
        if (REGISTER_OUT) begin : g_reg
            // Stage p1: output register; data and select only update on a valid capture
            logic [WIDTH-1:0] y_p1;
            logic [SEL_W-1:0] sel_p1;
            logic             vld_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    y_p1   <= '0;
                    sel_p1 <= SEL_I0;
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= in_valid;
                    if (in_valid) begin
                        y_p1   <= mux_p0;
                        sel_p1 <= sel_p0;
                    end
                end
            end

            assign y       = y_p1;
            assign sel_q   = sel_p1;
            assign y_valid = vld_p1;
        end else begin : g_comb
            // Clock and reset have no function here; folding them keeps them visibly consumed.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst;

            assign y       = mux_p0;
            assign sel_q   = sel_p0;
            assign y_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_mux4to1_reg.sv
// Scoreboard bench: registered instance (WIDTH=8) checked by a monitor, combinational instance (WIDTH=4) checked inline.
module tb_mux4to1_reg;

    typedef struct packed {
        logic       vld;
        logic [7:0] y;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] i0, i1, i2, i3;
    logic       s0, s1, in_valid;
    logic [7:0] y_r;
    logic       y_valid_r;
    logic [1:0] sel_q_r;

    logic       rst_c;
    logic [3:0] i0_c, i1_c, i2_c, i3_c;
    logic       s0_c, s1_c, in_valid_c;
    logic [3:0] y_c;
    logic       y_valid_c;
    logic [1:0] sel_q_c;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    logic [7:0] last_y;
    logic [1:0] last_sel;

    mux4to1_reg #(.WIDTH(8), .REGISTER_OUT(1'b1)) dut_r (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .s0(s0), .s1(s1), .in_valid(in_valid),
        .y(y_r), .y_valid(y_valid_r), .sel_q(sel_q_r)
    );

    mux4to1_reg #(.WIDTH(4), .REGISTER_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst_c), .i0(i0_c), .i1(i1_c), .i2(i2_c), .i3(i3_c),
        .s0(s0_c), .s1(s1_c), .in_valid(in_valid_c),
        .y(y_c), .y_valid(y_valid_c), .sel_q(sel_q_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("y_valid", 8'(y_valid_r), 8'(e.vld));
                check("y", y_r, e.y);
                check("sel_q", 8'(sel_q_r), 8'(e.sel));
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic ev, input logic [7:0] ey, input logic [1:0] es,
                         input bit glitch);
        exp_t e;
        @(negedge clk);
        if (glitch) begin
            i0 = 8'($urandom); i1 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
            {s1, s0} = 2'($urandom); in_valid = 1'b1;
            #1;
            check("glitch_y_stable", y_r, last_y);
            check("glitch_sel_stable", 8'(sel_q_r), 8'(last_sel));
            i0 = ~i0; i1 = ~i1; i2 = ~i2; i3 = ~i3; {s1, s0} = ~{s1, s0};
            #1;
        end
        rst = r; in_valid = v; {s1, s0} = s;
        i0 = a; i1 = b; i2 = c; i3 = d;
        e.vld = ev; e.y = ey; e.sel = es;
        sb_q.push_back(e);
        last_y = ey; last_sel = es;
    endtask

    initial begin
        logic [7:0] rv [4];
        logic [1:0] rs;
        logic       rvld;
        logic [3:0] cy [4];

        rst = 1'b1; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        rst_c = 1'b0; in_valid_c = 1'b0; s0_c = 1'b0; s1_c = 1'b0;
        i0_c = '0; i1_c = '0; i2_c = '0; i3_c = '0;
        last_y = '0; last_sel = '0;

        // Reset state
        drive(1, 0, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 0, 8'h00, 2'b00, 0);

        // Exhaustive select with 1-bit data values
        drive(0, 1, 2'b00, 8'h01, 8'h00, 8'h01, 8'h01, 1, 8'h01, 2'b00, 0);
        drive(0, 1, 2'b01, 8'h01, 8'h00, 8'h01, 8'h01, 1, 8'h00, 2'b01, 0);
        drive(0, 1, 2'b10, 8'h01, 8'h00, 8'h01, 8'h01, 1, 8'h01, 2'b10, 0);
        drive(0, 1, 2'b11, 8'h01, 8'h00, 8'h01, 8'h01, 1, 8'h01, 2'b11, 0);

        // Reset mid-stream overrides in_valid, then first valid after release
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hA5, 1, 8'hA5, 2'b11, 0);
        drive(1, 1, 2'b01, 8'h00, 8'h77, 8'h00, 8'hA5, 0, 8'h00, 2'b00, 0);
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h3C, 8'h00, 1, 8'h3C, 2'b10, 0);

        // Hold on invalid
        drive(0, 1, 2'b01, 8'h00, 8'h5A, 8'h00, 8'h00, 1, 8'h5A, 2'b01, 0);
        repeat (3) drive(0, 0, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 8'h5A, 2'b01, 0);

        // Inputs toggled between edges; only the value present at the edge counts
        drive(0, 1, 2'b10, 8'h10, 8'h20, 8'h30, 8'h40, 1, 8'h30, 2'b10, 1);
        drive(0, 1, 2'b00, 8'hC3, 8'h20, 8'h30, 8'h40, 1, 8'hC3, 2'b00, 1);
        drive(0, 0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h99, 0, 8'hC3, 2'b00, 1);

        // Random vectors with 1-bit data against a golden select
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 4; j++) rv[j] = 8'($urandom_range(0, 1));
            rs   = 2'($urandom_range(0, 3));
            rvld = 1'($urandom_range(0, 1));
            if (rvld)
                drive(0, 1, rs, rv[0], rv[1], rv[2], rv[3], 1, rv[rs], rs, 0);
            else
                drive(0, 0, rs, rv[0], rv[1], rv[2], rv[3], 0, last_y, last_sel, 0);
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        // Combinational instance: zero latency, rst and clk ignored
        i0_c = 4'h1; i1_c = 4'h2; i2_c = 4'h4; i3_c = 4'h8;
        cy[0] = 4'h1; cy[1] = 4'h2; cy[2] = 4'h4; cy[3] = 4'h8;
        for (int k = 0; k < 4; k++) begin
            {s1_c, s0_c} = 2'(k);
            in_valid_c = k[0];
            rst_c = k[1];
            #1;
            check("comb_y", 8'(y_c), 8'(cy[k]));
            check("comb_y_valid", 8'(y_valid_c), 8'(k[0]));
            check("comb_sel_q", 8'(sel_q_c), 8'(k));
        end
        {s1_c, s0_c} = 2'b10;
        rst_c = 1'b1;
        i2_c = 4'h7;
        #1;
        check("comb_follow_y", 8'(y_c), 8'h07);
        @(posedge clk);
        #1;
        check("comb_rst_ignored_y", 8'(y_c), 8'h07);
        rst_c = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4to1_reg.md
Name: mux4to1_reg

Overview:
- Parameterised 4-to-1 multiplexer with an optional registered output stage and valid qualifier.
- Selects one of four data inputs i0..i3 using a two-bit select formed from s1 (MSB) and s0 (LSB).
- Used as a generic datapath steering element; the registered mode breaks timing paths between source and consumer logic.

Parameters:
- WIDTH, 1, bit width of each data input and of y.
- REGISTER_OUT, 1, 1 = y/y_valid registered (1-cycle latency); 0 = y/y_valid purely combinational, clk/rst unused.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- i0  input  WIDTH  data selected when {s1,s0}=2'b00.
- i1  input  WIDTH  data selected when {s1,s0}=2'b01.
- i2  input  WIDTH  data selected when {s1,s0}=2'b10.
- i3  input  WIDTH  data selected when {s1,s0}=2'b11.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- in_valid  input  1  qualifies i0..i3/s0/s1 for capture.
- y  output  WIDTH  selected data.
- y_valid  output  1  y holds data captured from a valid input.
- sel_q  output  2  select value that produced the current y (registered or pass-through per mode).

Behaviour:
- Select mapping: sel = {s1,s0}; 00->i0, 01->i1, 10->i2, 11->i3. No other encodings exist; the decode is a full case with no latch.
- Combinational core: mux_out = input chosen by sel, all WIDTH bits, no inversion, no gating.
- REGISTER_OUT=1:
  - On each rising clk with rst=1: y<=0, y_valid<=0, sel_q<=2'b00. Reset overrides in_valid.
  - On a rising clk with rst=0 and in_valid=1: y<=mux_out, sel_q<=sel, y_valid<=1.
  - On a rising clk with rst=0 and in_valid=0: y and sel_q hold their previous values; y_valid<=0.
  - Latency is exactly one cycle from input to y, and throughput is one selection per cycle.
  - Reset asserted mid-stream clears the outputs on that edge; the first valid input after rst deasserts appears at the next edge.
  - Changing the inputs or select between edges has no effect on y.
- REGISTER_OUT=0:
  - y=mux_out, sel_q=sel, y_valid=in_valid, all combinational with zero latency.
  - clk and rst are ignored; y follows input changes within the same delta.
- X/Z on s0/s1 is not a supported input. There is no requirement on y in that case beyond synthesis equivalence.
- All outputs are driven in both modes.

Decomposition:
- Package mux4to1_pkg:
  - SEL_W=2.
  - Localparams SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
  - A sel_t typedef (logic [1:0]).
- Sub-module mux4_comb_core (parameter WIDTH): pure combinational 4:1 select, instantiated once.
- Top mux4to1_reg: wraps the core and implements the register stage via a generate branch on REGISTER_OUT.

Test Plan:
1. Exhaustive select, WIDTH=1, REGISTER_OUT=1: i0..i3=1,0,1,1. Step sel 00,01,10,11 with in_valid=1 on consecutive cycles -> one cycle later y=1,0,1,1, sel_q matches, y_valid=1.
2. Reset, WIDTH=8, REGISTER_OUT=1: y holds 8'hA5. Assert rst for one edge with in_valid=1 -> y=8'h00, y_valid=0, sel_q=00 after that edge. Deassert rst with sel=10, i2=8'h3C -> y=8'h3C, y_valid=1 on the next edge.
3. Hold on invalid, WIDTH=8, REGISTER_OUT=1: capture i1=8'h5A (sel=01). Then in_valid=0 with sel=11, i3=8'hFF for 3 cycles -> y stays 8'h5A, sel_q=01, y_valid=0.
4. Mid-cycle input glitch, REGISTER_OUT=1: toggle s0/s1 and i0..i3 between edges -> y changes only at rising edges, to the value of the select present at the edge.
5. Combinational mode, WIDTH=4, REGISTER_OUT=0: i0..i3=4'h1,4'h2,4'h4,4'h8, sweep sel -> y=4'h1,4'h2,4'h4,4'h8 in the same timestep, y_valid tracks in_valid, and toggling rst has no effect.
6. Random regression, 10+ vectors, WIDTH=1, random {i0..i3}, s0, s1, in_valid -> y equals the golden model select result, delayed one cycle when REGISTER_OUT=1.
